// File: rtl/fp32_uart_tx_32.sv
// fp32_uart_tx_32: 8N1 UART transmitter that sends one 32-bit word as 4 bytes, LSB byte first.
// Defining FP32_TX_CHECKSUM_EN appends a fifth byte holding the XOR of the four data bytes.
module fp32_uart_tx_32 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 4
) (
  input  logic        CLK_I,
  input  logic        RSTL_I,
  input  logic        TX_VALID_I,
  input  logic [31:0] TX_DATA_I,
  output logic        TX_READY_O,
  output logic        TX_DATA_O
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
`ifdef FP32_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES);
`else
  localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
`endif
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [7:0]    shift;
  logic [31:0]   word;
  logic [7:0]    next_byte;
  logic          baud_done;
  assign baud_done = baud_cnt == BAUD_MAX;
`ifdef FP32_TX_CHECKSUM_EN
  logic [7:0] csum;
  // word is shifted down one byte per byte sent, so word[15:8] is always the next data byte
  assign next_byte = (byte_idx == 3'(NUM_BYTES - 1)) ? csum : word[15:8];
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I)
      csum <= '0;
    else if (state == IDLE && TX_VALID_I)
      csum <= TX_DATA_I[7:0];
    else if (state == STOP && baud_done && byte_idx != LAST_BYTE)
      csum <= csum ^ word[15:8];
  end
`else
  assign next_byte = word[15:8];
`endif
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      word       <= '0;
      TX_DATA_O  <= 1'b1;
      TX_READY_O <= 1'b1;
    end else begin
      case (state)
        IDLE: if (TX_VALID_I) begin
          word       <= TX_DATA_I;
          shift      <= TX_DATA_I[7:0];
          byte_idx   <= '0;
          baud_cnt   <= '0;
          TX_DATA_O  <= 1'b0;
          TX_READY_O <= 1'b0;
          state      <= START;
        end
        START: if (baud_done) begin
          baud_cnt  <= '0;
          bit_idx   <= '0;
          TX_DATA_O <= shift[0];
          shift     <= {1'b0, shift[7:1]};
          state     <= DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        DATA: if (baud_done) begin
          baud_cnt <= '0;
          if (bit_idx == 3'd7) begin
            TX_DATA_O <= 1'b1;
            state     <= STOP;
          end else begin
            bit_idx   <= bit_idx + 1'b1;
            TX_DATA_O <= shift[0];
            shift     <= {1'b0, shift[7:1]};
          end
        end else baud_cnt <= baud_cnt + 1'b1;
        STOP: if (baud_done) begin
          baud_cnt <= '0;
          if (byte_idx == LAST_BYTE) begin
            TX_READY_O <= 1'b1;
            state      <= IDLE;
          end else begin
            byte_idx  <= byte_idx + 1'b1;
            word      <= {8'd0, word[31:8]};
            shift     <= next_byte;
            TX_DATA_O <= 1'b0;
            state     <= START;
          end
        end else baud_cnt <= baud_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
